pulse_scheduler: RTL and testbench
==================================

# pulse_scheduler

Round-robin controller that shares one serial pulse output among several requesters. Each requester offers a WIDTH-bit pattern. The scheduler grants one requester at a time, latches its pattern and shifts it out MSB-first on `pulse_out`. It then inserts a programmable idle gap before the next grant. It sequences the lab's pulse-generation path and replaces manual `load_flag` toggling with a request/acknowledge handshake.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be ≥2.
- `WIDTH`, default 16: pattern length in bits.
- `GAP`, default 2: idle cycles after each frame; 0 is allowed.
- `clock`  in  1  rising-edge system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester request level; held until the matching `ack`.
- `pattern`  in  NUM_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]; must be valid while `req[i]` is high.
- `ack`  out  NUM_REQ  one-cycle pulse: pattern i has been latched.
- `done`  out  NUM_REQ  one-cycle pulse: last bit of frame i has been emitted.
- `pulse_out`  out  1  serial frame data; 0 when not shifting.
- `busy`  out  1  high whenever state ≠ IDLE.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or most recent grant.

## Operation
- States: IDLE, SHIFT, GAP.
- **IDLE**
  - On an edge with `req` ≠ 0, the winner is the first set bit searching upward from `(last_grant+1) mod NUM_REQ`, with wrap-around.
  - On that edge: `shreg` ← winner's pattern; `grant_id` and `last_grant` ← winner; `ack[winner]` ← 1; `bit_cnt` ← 0; next state SHIFT.
- **SHIFT**
  - `pulse_out` = `shreg[WIDTH-1]`. Each edge shifts `shreg` left by one and increments `bit_cnt`.
  - On the edge where `bit_cnt` == WIDTH-1: `done[grant_id]` ← 1; next state GAP, or IDLE if GAP = 0.
- **GAP**
  - `gap_cnt` counts GAP cycles; then next state IDLE. `pulse_out` = 0.
- `req` is ignored outside IDLE. A request that is still high in IDLE after its `done` is treated as a new request.
- `ack` and `done` are registered and cleared on the following edge. At most one bit of each is high at a time.
- Reset values:
  - All outputs 0; state IDLE.
  - `last_grant` = NUM_REQ-1, so requester 0 has first priority.
  - `shreg`, `bit_cnt` and `gap_cnt` = 0.
- Reset mid-frame: outputs clear immediately, the frame is discarded, and no `done` is issued. After release, arbitration restarts from requester 0's priority.

## Timing
- Accept edge E0: `ack` and `busy` high in the cycle E0→E1.
- `pulse_out` shows `pattern[WIDTH-1-k]` in cycle E_k→E_(k+1), for k = 0..WIDTH-1.
- `done` high in cycle E_WIDTH→E_(WIDTH+1). State becomes IDLE at E_(WIDTH+GAP).
- The earliest next accept is edge E_(WIDTH+GAP+1). Frame-to-frame period is therefore WIDTH+GAP+1 cycles (19 with the defaults).
- `busy` is high for WIDTH+GAP cycles per frame.
- Simultaneous requests: exactly one is granted per IDLE edge; the others wait without an `ack`.

## Structure
- Shared package `pulse_sched_pkg`:
  - state encoding localparams `ST_IDLE`, `ST_SHIFT`, `ST_GAP`;
  - default WIDTH, GAP and NUM_REQ constants.
- Sub-module `rr_arbiter` (combinational): inputs `req` and `last_grant`; outputs winner index and a valid flag.
- Shift register, counters and FSM live in `pulse_scheduler`.
- Target size: 150–250 lines.

## Test plan
- **Single frame:** after reset, `req[0]`=1 with pattern 16'hA5C3.
  - `ack[0]` high 1 cycle after the edge; `grant_id`=0.
  - `pulse_out` = 1010 0101 1100 0011 over 16 cycles.
  - `done[0]` at E16; `busy` high for 18 cycles.
- **All requesting:** `req`=4'b1111 from reset, each requester dropping its `req` on its `ack`.
  - Grants in order 0,1,2,3, accepts spaced 19 cycles apart, each `done` matching its `grant_id`.
- **Fairness:** `req[1]` and `req[3]` held high permanently.
  - Grant sequence 1,3,1,3; requester 1 never wins twice in a row.
- **Reset mid-frame:** `reset` pulsed at k=7.
  - `pulse_out`, `busy` and `ack` go to 0 at once; no `done`.
  - After release with `req[2]` only: grant 2 on the first edge.
- **Pattern extremes:** patterns 16'h0000 then 16'hFFFF.
  - `pulse_out` constant 0 then constant 1 for 16 cycles; `done` issued for both frames.
- **GAP=0 instance:** back-to-back requesters give accepts 17 cycles apart, with `pulse_out` 0 for exactly the one IDLE cycle between frames.

Source files
------------

// File: rtl/pulse_sched_pkg.sv
// Shared definitions for the pulse scheduler slice.
//   - default NUM_REQ / WIDTH / GAP constants
//   - FSM state encoding (ST_IDLE, ST_SHIFT, ST_GAP)
//   - helper for sizing counters that must hold values 0..n-1
package pulse_sched_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 16;
    localparam int DEF_GAP     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Width of a counter covering 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pulse_scheduler_if.sv
// Requester-side bus of the pulse scheduler.
//   req     : per-requester request level
//   pattern : requester i occupies bits [i*WIDTH +: WIDTH]
//   ack     : one-cycle pulse, pattern i has been latched
//   done    : one-cycle pulse, last bit of frame i has been emitted
//
// Handshake: a requester raises req[i] with a stable pattern and holds both
// until it sees ack[i]; the pattern may change once ack[i] has been seen.
// A req[i] still high when the scheduler next returns to IDLE counts as a
// fresh request.
interface pulse_scheduler_if
    import pulse_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] pattern;
    logic [NUM_REQ-1:0]       ack;
    logic [NUM_REQ-1:0]       done;

    modport master (output req, output pattern, input ack, input done);
    modport slave  (input req, input pattern, output ack, output done);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        : request vector
//   last_grant : index of the previous winner
//   winner     : first set request searching upward from last_grant+1, wrapping
//   valid      : at least one request is set
module rr_arbiter
    import pulse_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [IW-1:0]      winner,
    output logic               valid
);

    logic [IW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        // Offset NUM_REQ wraps back to last_grant itself, so a lone
        // requester can win repeatedly.
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = IW'((int'(last_grant) + off) % NUM_REQ);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/pulse_scheduler.sv
// Round-robin pulse scheduler: grants one requester at a time, latches its
// pattern, shifts it out MSB-first on pulse_out, then idles GAP cycles.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus          : requester bus (req/pattern in, ack/done out)
//   pulse_out    : serial frame data, 0 when not shifting
//   busy         : high whenever the FSM is not in IDLE
//   grant_id     : index of the current or most recent grant
//   state_dbg    : FSM state
module pulse_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int GAP     = DEF_GAP
) (
    input  logic                       clock,
    input  logic                       reset,
    pulse_scheduler_if.slave           bus,
    output logic                       pulse_out,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output state_t                     state_dbg
);

    localparam int IW  = $clog2(NUM_REQ);
    localparam int BCW = cnt_width(WIDTH);
    localparam int GCW = cnt_width(GAP);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP > 0) ? GAP - 1 : 0);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   shreg;
    logic [BCW-1:0]     bit_cnt;
    logic [GCW-1:0]     gap_cnt;
    logic [IW-1:0]      last_grant;
    logic [IW-1:0]      winner;
    logic               win_valid;
    logic [WIDTH-1:0]   pat_sel;
    logic [NUM_REQ-1:0] ack_q;
    logic [NUM_REQ-1:0] done_q;
    logic               accept;
    logic               frame_end;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .req        (bus.req),
        .last_grant (last_grant),
        .winner     (winner),
        .valid      (win_valid)
    );

    always_comb begin
        pat_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IW'(i)) pat_sel = bus.pattern[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        frame_end = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt == BIT_LAST) begin
                    frame_end = 1'b1;
                    state_nxt = (GAP == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            grant_id   <= '0;
            ack_q      <= '0;
            done_q     <= '0;
        end else begin
            ack_q  <= '0;
            done_q <= '0;
            if (accept) begin
                shreg      <= pat_sel;
                grant_id   <= winner;
                last_grant <= winner;
                ack_q      <= NUM_REQ'(1) << winner;
                bit_cnt    <= '0;
                gap_cnt    <= '0;
            end else if (state == ST_SHIFT) begin
                shreg   <= {shreg[WIDTH-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
                if (frame_end) done_q <= NUM_REQ'(1) << grant_id;
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    // Combinational from state so an asynchronous reset silences the line
    // immediately.
    assign pulse_out = (state == ST_SHIFT) & shreg[WIDTH-1];
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;
    assign bus.ack   = ack_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Bench for pulse_scheduler: dut_a uses GAP=2, dut_b uses GAP=0.
// Drivers push expected frames {spacing, id, pattern} into a queue per DUT;
// the negedge monitor pops one at each ack and follows the frame bit by bit.
module tb_pulse_scheduler;
    import pulse_sched_pkg::*;

    logic clock;
    logic reset;

    pulse_scheduler_if #(.NUM_REQ(4), .WIDTH(16)) bus_a ();
    pulse_scheduler_if #(.NUM_REQ(4), .WIDTH(16)) bus_b ();

    logic       pulse_a, busy_a, pulse_b, busy_b;
    logic [1:0] gid_a, gid_b;
    state_t     st_a, st_b;

    pulse_scheduler #(.NUM_REQ(4), .WIDTH(16), .GAP(2)) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a),
        .pulse_out(pulse_a), .busy(busy_a), .grant_id(gid_a), .state_dbg(st_a)
    );

    pulse_scheduler #(.NUM_REQ(4), .WIDTH(16), .GAP(0)) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b),
        .pulse_out(pulse_b), .busy(busy_b), .grant_id(gid_b), .state_dbg(st_b)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    // {spacing[7:0] (0 = unchecked), id[1:0], pattern[15:0]}
    logic [25:0] exp_qa[$];
    logic [25:0] exp_qb[$];

    bit          in_frame[2];
    int          kk[2];
    logic [25:0] cur[2];
    int          last_acc[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon_step(input int d, input logic [3:0] ack, input logic [3:0] done,
                            input logic po, input logic bz, input logic [1:0] gid,
                            input state_t st);
        int          gap;
        int          k;
        string       p;
        logic [25:0] it;
        logic [15:0] pat;
        logic [1:0]  id;
        gap = (d == 0) ? 2 : 0;
        p   = (d == 0) ? "a_" : "b_";
        if (reset) begin
            in_frame[d] = 1'b0;
            return;
        end
        if (!in_frame[d]) begin
            if (ack != 4'b0) begin
                if ((d == 0 && exp_qa.size() == 0) || (d == 1 && exp_qb.size() == 0)) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %sunexpected_ack: got ack %0h, no frame expected (t=%0t)", p, ack, $time);
                    return;
                end
                it      = (d == 0) ? exp_qa.pop_front() : exp_qb.pop_front();
                cur[d]  = it;
                id      = it[17:16];
                pat     = it[15:0];
                check({p, "ack_onehot"}, 32'(ack), 32'(4'b0001 << id));
                check({p, "grant_id"}, 32'(gid), 32'(id));
                check({p, "busy_at_ack"}, 32'(bz), 32'd1);
                check({p, "pulse_k0"}, 32'(po), 32'(pat[15]));
                if (it[25:18] != 8'd0)
                    check({p, "accept_spacing"}, 32'(cyc - last_acc[d]), 32'(it[25:18]));
                last_acc[d] = cyc;
                in_frame[d] = 1'b1;
                kk[d]       = 1;
            end else begin
                check({p, "idle_done"}, 32'(done), 32'd0);
                check({p, "idle_pulse"}, 32'(po), 32'd0);
                check({p, "idle_busy"}, 32'(bz), 32'd0);
            end
        end else begin
            k   = kk[d];
            id  = cur[d][17:16];
            pat = cur[d][15:0];
            check({p, "frame_ack"}, 32'(ack), 32'd0);
            check({p, "frame_grant_id"}, 32'(gid), 32'(id));
            if (k < 16) begin
                check({p, "pulse_bit"}, 32'(po), 32'(pat[15-k]));
                check({p, "frame_done_early"}, 32'(done), 32'd0);
                check({p, "busy_shift"}, 32'(bz), 32'd1);
                check({p, "state_shift"}, 32'(st), 32'(ST_SHIFT));
            end else begin
                check({p, "pulse_after_frame"}, 32'(po), 32'd0);
                if (k == 16) check({p, "done_onehot"}, 32'(done), 32'(4'b0001 << id));
                else         check({p, "done_extra"}, 32'(done), 32'd0);
                if (k >= 16 + gap) begin
                    check({p, "busy_end"}, 32'(bz), 32'd0);
                    check({p, "state_idle"}, 32'(st), 32'(ST_IDLE));
                    in_frame[d] = 1'b0;
                end else begin
                    check({p, "busy_gap"}, 32'(bz), 32'd1);
                    check({p, "state_gap"}, 32'(st), 32'(ST_GAP));
                end
            end
            kk[d] = k + 1;
        end
    endtask

    always @(negedge clock) begin
        mon_step(0, bus_a.ack, bus_a.done, pulse_a, busy_a, gid_a, st_a);
        mon_step(1, bus_b.ack, bus_b.done, pulse_b, busy_b, gid_b, st_b);
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ack(input int d, output int lat);
        lat = 0;
        while (1) begin
            @(negedge clock);
            lat++;
            if (((d == 0) ? bus_a.ack : bus_b.ack) != 4'b0) break;
            if (lat >= 100) begin
                n_tests++;
                n_fail++;
                $display("FAIL wait_ack_timeout: dut %0d no ack within %0d cycles", d, lat);
                break;
            end
        end
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (1) begin
            @(negedge clock);
            n++;
            if (((d == 0) ? busy_a : busy_b) == 1'b0) break;
            if (n >= 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL wait_idle_timeout: dut %0d busy for %0d cycles", d, n);
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        #2 reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] pats[4];
    int          lat;

    initial begin
        reset         = 1'b1;
        bus_a.req     = '0;
        bus_a.pattern = '0;
        bus_b.req     = '0;
        bus_b.pattern = '0;
        repeat (3) @(negedge clock);

        // reset state
        check("rst_a_pulse", 32'(pulse_a), 32'd0);
        check("rst_a_busy", 32'(busy_a), 32'd0);
        check("rst_a_ack", 32'(bus_a.ack), 32'd0);
        check("rst_a_done", 32'(bus_a.done), 32'd0);
        check("rst_a_grant_id", 32'(gid_a), 32'd0);
        check("rst_a_state", 32'(st_a), 32'(ST_IDLE));
        check("rst_b_busy", 32'(busy_b), 32'd0);
        check("rst_b_pulse", 32'(pulse_b), 32'd0);
        #2 reset = 1'b0;

        // single frame
        @(negedge clock);
        bus_a.pattern = {48'h0, 16'hA5C3};
        bus_a.req     = 4'b0001;
        exp_qa.push_back({8'd0, 2'd0, 16'hA5C3});
        wait_ack(0, lat);
        check("single_ack_latency", 32'(lat), 32'd1);
        bus_a.req = '0;
        wait_idle(0);

        // all requesting from reset, grants 0,1,2,3 spaced 19 cycles
        pulse_reset();
        @(negedge clock);
        pats[0] = 16'h8001; pats[1] = 16'h1234; pats[2] = 16'hBEEF; pats[3] = 16'h7FFE;
        bus_a.pattern = {pats[3], pats[2], pats[1], pats[0]};
        bus_a.req     = 4'b1111;
        for (int i = 0; i < 4; i++)
            exp_qa.push_back({(i == 0) ? 8'd0 : 8'd19, 2'(i), pats[i]});
        for (int i = 0; i < 4; i++) begin
            wait_ack(0, lat);
            bus_a.req = bus_a.req & ~bus_a.ack;
        end
        wait_idle(0);

        // fairness: req[1] and req[3] held high, grants 1,3,1,3
        pats[1] = 16'hC0DE; pats[3] = 16'h0001;
        bus_a.pattern = {pats[3], 16'h0, pats[1], 16'h0};
        bus_a.req     = 4'b1010;
        exp_qa.push_back({8'd0,  2'd1, pats[1]});
        exp_qa.push_back({8'd19, 2'd3, pats[3]});
        exp_qa.push_back({8'd19, 2'd1, pats[1]});
        exp_qa.push_back({8'd19, 2'd3, pats[3]});
        for (int i = 0; i < 4; i++) wait_ack(0, lat);
        bus_a.req = '0;
        wait_idle(0);

        // pattern extremes
        bus_a.pattern = {48'h0, 16'h0000};
        bus_a.req     = 4'b0001;
        exp_qa.push_back({8'd0, 2'd0, 16'h0000});
        wait_ack(0, lat);
        bus_a.req = '0;
        wait_idle(0);
        bus_a.pattern = {48'h0, 16'hFFFF};
        bus_a.req     = 4'b0001;
        exp_qa.push_back({8'd0, 2'd0, 16'hFFFF});
        wait_ack(0, lat);
        bus_a.req = '0;
        wait_idle(0);

        // reset at k=7 of an all-ones frame, then req[2] alone
        bus_a.pattern = {16'h0, 16'h5A5A, 16'h0, 16'hFFFF};
        bus_a.req     = 4'b0001;
        exp_qa.push_back({8'd0, 2'd0, 16'hFFFF});
        wait_ack(0, lat);
        bus_a.req = '0;
        repeat (7) @(negedge clock);
        check("pre_reset_pulse", 32'(pulse_a), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_pulse", 32'(pulse_a), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_ack", 32'(bus_a.ack), 32'd0);
        check("midrst_done", 32'(bus_a.done), 32'd0);
        @(negedge clock);
        check("midrst_state", 32'(st_a), 32'(ST_IDLE));
        #2 reset = 1'b0;
        bus_a.req = 4'b0100;
        exp_qa.push_back({8'd0, 2'd2, 16'h5A5A});
        wait_ack(0, lat);
        check("post_rst_ack_latency", 32'(lat), 32'd1);
        check("post_rst_ack", 32'(bus_a.ack), 32'(4'b0100));
        bus_a.req = '0;
        wait_idle(0);

        // GAP=0: back-to-back frames 17 cycles apart
        @(negedge clock);
        bus_b.pattern = {32'h0, 16'h0FF0, 16'hF00F};
        bus_b.req     = 4'b0011;
        exp_qb.push_back({8'd0,  2'd0, 16'hF00F});
        exp_qb.push_back({8'd17, 2'd1, 16'h0FF0});
        for (int i = 0; i < 2; i++) begin
            wait_ack(1, lat);
            bus_b.req = bus_b.req & ~bus_b.ack;
        end
        wait_idle(1);
        repeat (3) @(negedge clock);

        check("queue_a_drained", 32'(exp_qa.size()), 32'd0);
        check("queue_b_drained", 32'(exp_qb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
